or16_accum: RTL and testbench
=============================

// Module: or16_accum
// PURPOSE
//  Downstream consumer of the Or16 datapath. Takes a valid/ready stream of
//  16-bit words, ORs a frame of LEN+1 consecutive words into an accumulator,
//  then presents the frame result plus an any-bit-set flag (Or16Way) on a
//  valid/ready output. Used as a bus-activity and sticky-flag collector behind
//  the bitwise logic stage.
// PARAMETERS
//  WIDTH    16  data width of input words and result
//  LEN_W    4   width of frame-length field; frame = len+1 words (1..2^LEN_W)
// PORTS
//  clk        in   1      rising-edge clock, the only clock
//  reset      in   1      synchronous, active-high reset
//  len        in   LEN_W  frame length minus one; sampled on first beat only
//  in_data    in   WIDTH  input word (e.g. Or16 out)
//  in_valid   in   1      in_data is valid this cycle
//  in_ready   out  1      block accepts in_data this cycle
//  out_data   out  WIDTH  OR of all words in the completed frame
//  out_any    out  1      |out_data (Or16Way of the result)
//  out_valid  out  1      out_data/out_any are valid
//  out_ready  in   1      consumer takes the result this cycle
//  busy       out  1      frame in progress or result pending (state != IDLE)
// BEHAVIOUR
//  - Reset (sync, clk edge with reset=1): state=IDLE, acc=0, remaining=0,
//    out_valid=0, out_data=0, out_any=0, busy=0. Reset wins over all events;
//    partial frame or pending result is dropped, nothing emitted.
//  - Beat = in_valid & in_ready at a clk edge. Output handshake =
//    out_valid & out_ready.
//  - FSM states: IDLE, ACCUM, DONE.
//    IDLE : in_ready=1. On beat: acc<=in_data, remaining<=len.
//           len==0 -> DONE; else -> ACCUM.
//    ACCUM: in_ready=1. On beat: acc<=acc|in_data, remaining<=remaining-1;
//           remaining==1 -> DONE, else stay. No beat: hold all.
//    DONE : in_ready=0, out_valid=1. On output handshake -> IDLE.
//           Otherwise hold; out_data/out_any stable while stalled.
//  - out_data=acc, out_any=|acc, driven from registers (no comb in->out).
//  - Latency: out_valid rises the cycle after the last beat of the frame.
//    No bypass from DONE to a new frame. Min period per frame = len+2 cycles.
//  - in_valid gaps inside a frame are allowed; they extend the frame in time,
//    not in word count. len changes mid-frame are ignored.
//  - in_data ignored when in_ready=0; out_ready ignored when out_valid=0.
//  - OR is bitwise across WIDTH; no carries, no overflow. remaining counts
//    down only; it never wraps (max len = 2^LEN_W-1 gives 2^LEN_W beats).
// TESTING
//  1. reset=1 for 2 cycles, random inputs -> out_valid=0, out_data=0, busy=0,
//     in_ready=1 after release.
//  2. len=0, beat in_data=16'hA5A5 -> next cycle out_valid=1,
//     out_data=16'hA5A5, out_any=1; out_ready=1 -> IDLE.
//  3. len=3, beats 16'h0001,16'h0010,16'h0100,16'h1000 with 1-cycle gaps
//     between -> out_data=16'h1111 exactly one cycle after the 4th beat.
//  4. len=15, 16 beats of 16'h0000 -> out_data=16'h0000, out_any=0;
//     hold out_ready=0 for 5 cycles -> out stable, in_ready=0 throughout.
//  5. len=2, 2 beats then reset=1 -> IDLE, out_valid never asserted; a new
//     len=0 frame 16'hFFFF -> out_data=16'hFFFF.
//  6. Mid-frame len change (3 -> 0) after first beat -> frame still 4 beats.

Source files
------------

// File: rtl/or16_accum_if.sv
// Valid/ready stream bundle for or16_accum: word input, frame length and OR result output.
interface or16_accum_if #(
    parameter int WIDTH = 16,
    parameter int LEN_W = 4
);
    logic [LEN_W-1:0] len;
    logic [WIDTH-1:0] in_data;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] out_data;
    logic             out_any;
    logic             out_valid;
    logic             out_ready;

    modport master (
        output len, in_data, in_valid, out_ready,
        input  in_ready, out_data, out_any, out_valid
    );

    modport slave (
        input  len, in_data, in_valid, out_ready,
        output in_ready, out_data, out_any, out_valid
    );
endinterface

// File: rtl/or16_accum.sv
// Bitwise-OR collector over a frame of len+1 words; result valid the cycle after the last beat.
// in_ready drops while a result is pending; the result holds until out_ready takes it.
module or16_accum #(
    parameter int WIDTH = 16,
    parameter int LEN_W = 4
) (
    input  logic         clk,
    input  logic         reset,
    or16_accum_if.slave  bus,
    output logic         busy
);
    typedef enum logic [1:0] {IDLE, ACCUM, DONE} state_t;

    state_t           state, state_nxt;
    logic [WIDTH-1:0] acc, acc_nxt;
    logic [LEN_W-1:0] remaining, remaining_nxt;
    logic             beat;

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            acc       <= '0;
            remaining <= '0;
        end else begin
            state     <= state_nxt;
            acc       <= acc_nxt;
            remaining <= remaining_nxt;
        end
    end

    always_comb begin
        state_nxt     = state;
        acc_nxt       = acc;
        remaining_nxt = remaining;
        bus.in_ready  = 1'b0;
        bus.out_valid = 1'b0;
        beat          = 1'b0;
        case (state)
            IDLE: begin
                bus.in_ready = 1'b1;
                beat         = bus.in_valid;
                if (beat) begin
                    // len is captured only here, so later changes cannot resize the frame
                    acc_nxt       = bus.in_data;
                    remaining_nxt = bus.len;
                    state_nxt     = (bus.len == '0) ? DONE : ACCUM;
                end
            end
            ACCUM: begin
                bus.in_ready = 1'b1;
                beat         = bus.in_valid;
                if (beat) begin
                    acc_nxt       = acc | bus.in_data;
                    remaining_nxt = remaining - 1'b1;
                    if (remaining == LEN_W'(1)) state_nxt = DONE;
                end
            end
            DONE: begin
                bus.out_valid = 1'b1;
                if (bus.out_ready) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign bus.out_data = acc;
    assign bus.out_any  = |acc;
    assign busy         = (state != IDLE);
endmodule

// File: tb/tb_or16_accum.sv
// Directed bench for or16_accum: reset, single/multi-word frames, gaps, stalls, abort, len change.
module tb_or16_accum;
    logic clk;
    logic reset;
    logic busy;
    int   checks;
    int   failures;

    or16_accum_if #(.WIDTH(16), .LEN_W(4)) bus ();

    or16_accum #(.WIDTH(16), .LEN_W(4)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave),
        .busy  (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Advance one edge; inputs change and outputs are sampled 1 time unit after it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic beat(input logic [15:0] d);
        bus.in_valid = 1'b1;
        bus.in_data  = d;
        tick();
        bus.in_valid = 1'b0;
        bus.in_data  = 16'h0;
    endtask

    task automatic take(input string tag);
        bus.out_ready = 1'b1;
        tick();
        bus.out_ready = 1'b0;
        chk({tag, "_after_take_valid"}, 32'(bus.out_valid), 32'd0);
        chk({tag, "_after_take_busy"}, 32'(busy), 32'd0);
    endtask

    initial begin
        checks        = 0;
        failures      = 0;
        reset         = 1'b1;
        bus.len       = 4'($urandom);
        bus.in_data   = 16'($urandom);
        bus.in_valid  = 1'b1;
        bus.out_ready = 1'($urandom);

        // 1: reset with random inputs
        tick();
        bus.in_data = 16'($urandom);
        tick();
        chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
        chk("rst_out_data", 32'(bus.out_data), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        reset         = 1'b0;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        tick();
        chk("rst_in_ready", 32'(bus.in_ready), 32'd1);
        chk("rst_idle_busy", 32'(busy), 32'd0);
        chk("rst_idle_valid", 32'(bus.out_valid), 32'd0);

        // 2: single-word frame
        bus.len = 4'd0;
        beat(16'hA5A5);
        chk("t2_valid", 32'(bus.out_valid), 32'd1);
        chk("t2_data", 32'(bus.out_data), 32'h0000A5A5);
        chk("t2_any", 32'(bus.out_any), 32'd1);
        chk("t2_in_ready", 32'(bus.in_ready), 32'd0);
        chk("t2_busy", 32'(busy), 32'd1);
        take("t2");

        // 3: four words with one-cycle gaps
        bus.len = 4'd3;
        beat(16'h0001);
        tick();
        chk("t3_gap_busy", 32'(busy), 32'd1);
        chk("t3_gap_in_ready", 32'(bus.in_ready), 32'd1);
        beat(16'h0010);
        tick();
        beat(16'h0100);
        tick();
        chk("t3_pre_last_valid", 32'(bus.out_valid), 32'd0);
        beat(16'h1000);
        chk("t3_valid", 32'(bus.out_valid), 32'd1);
        chk("t3_data", 32'(bus.out_data), 32'h00001111);
        chk("t3_any", 32'(bus.out_any), 32'd1);
        take("t3");

        // 4: maximum frame of zeros, then a 5-cycle stall with in_valid driven
        bus.len = 4'd15;
        for (int i = 0; i < 15; i++) beat(16'h0000);
        chk("t4_pre_last_valid", 32'(bus.out_valid), 32'd0);
        beat(16'h0000);
        chk("t4_valid", 32'(bus.out_valid), 32'd1);
        chk("t4_data", 32'(bus.out_data), 32'd0);
        chk("t4_any", 32'(bus.out_any), 32'd0);
        bus.in_valid = 1'b1;
        bus.in_data  = 16'hFFFF;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk($sformatf("t4_stall%0d_valid", i), 32'(bus.out_valid), 32'd1);
            chk($sformatf("t4_stall%0d_data", i), 32'(bus.out_data), 32'd0);
            chk($sformatf("t4_stall%0d_in_ready", i), 32'(bus.in_ready), 32'd0);
        end
        bus.in_valid = 1'b0;
        bus.in_data  = 16'h0;
        take("t4");

        // 5: abort a partial frame with reset, then a fresh single-word frame
        bus.len = 4'd2;
        beat(16'h0F0F);
        beat(16'hF0F0);
        chk("t5_partial_valid", 32'(bus.out_valid), 32'd0);
        chk("t5_partial_busy", 32'(busy), 32'd1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("t5_abort_valid", 32'(bus.out_valid), 32'd0);
        chk("t5_abort_busy", 32'(busy), 32'd0);
        chk("t5_abort_data", 32'(bus.out_data), 32'd0);
        tick();
        chk("t5_idle_valid", 32'(bus.out_valid), 32'd0);
        bus.len = 4'd0;
        beat(16'hFFFF);
        chk("t5_valid", 32'(bus.out_valid), 32'd1);
        chk("t5_data", 32'(bus.out_data), 32'h0000FFFF);
        take("t5");

        // 6: len changes after the first beat; frame stays four words
        bus.len = 4'd3;
        beat(16'h0003);
        bus.len = 4'd0;
        beat(16'h0030);
        chk("t6_after2_valid", 32'(bus.out_valid), 32'd0);
        beat(16'h0300);
        chk("t6_after3_valid", 32'(bus.out_valid), 32'd0);
        beat(16'h3000);
        chk("t6_valid", 32'(bus.out_valid), 32'd1);
        chk("t6_data", 32'(bus.out_data), 32'h00003333);
        take("t6");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
